// File: rtl/aes_key_expand_pkg.sv
// Shared AES key-schedule constants: Nk/Nr per key length, key_len encoding, FSM states.
// Latency: none (package only).
// Backpressure: not applicable.
package aes_const;

    localparam int NK_128 = 4;
    localparam int NR_128 = 10;
    localparam int NK_192 = 6;
    localparam int NR_192 = 12;
    localparam int NK_256 = 8;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Words in the cipher key; the reserved encoding behaves as AES-128.
    function automatic logic [3:0] nk_of(key_len_e kl);
        case (kl)
            KEY_192: return 4'(NK_192);
            KEY_256: return 4'(NK_256);
            default: return 4'(NK_128);
        endcase
    endfunction

    // Number of cipher rounds for the key length.
    function automatic logic [3:0] nr_of(key_len_e kl);
        case (kl)
            KEY_192: return 4'(NR_192);
            KEY_256: return 4'(NR_256);
            default: return 4'(NR_128);
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request / round-key read bundle between the round datapath and the key-schedule engine.
// Latency: none (wires only).
// Backpressure: master may only start when ready is high; rk read has no wait states.
interface aes_key_expand_if;

    logic [255:0] key;       // cipher key, left-justified
    logic [1:0]   key_len;   // 0:128 1:192 2:256 3:treated as 128
    logic         start;     // expansion request
    logic         ready;     // engine can accept a request
    logic         busy;      // expansion in progress
    logic         done;      // one-cycle completion pulse
    logic         rk_valid;  // round-key store holds a complete schedule
    logic [3:0]   rk_addr;   // round-key index
    logic [127:0] rk;        // selected round key

    modport master (
        output key, key_len, start, rk_addr,
        input  ready, busy, done, rk_valid, rk
    );

    modport slave (
        input  key, key_len, start, rk_addr,
        output ready, busy, done, rk_valid, rk
    );

endinterface

// File: rtl/aes_key_expand_sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word (byte 0 = MSB).
// Latency: combinational.
// Backpressure: none.
// Ports: sbox_i (256-entry table), word_i (input word), word_o (substituted word).
module aes_sub_word (
    input  logic [7:0]  sbox_i [0:255],
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox_i[word_i[31:24]],
                     sbox_i[word_i[23:16]],
                     sbox_i[word_i[15:8]],
                     sbox_i[word_i[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: loads the cipher key, then derives one round-key word per clock.
// Latency: accept edge to done = 40 / 46 / 52 cycles (AES-128/192/256); rk read is combinational.
// Backpressure: ready low during EXPAND, start ignored then; rk returns 0 until rk_valid.
//
// Ports: clock, reset (async, active-high); SBox/RCon tables from aes_array;
//        kx (slave modport): key/key_len/start request, ready/busy/done/rk_valid status,
//        rk_addr -> rk round-key read port.
// Build option AES_KEY_LONG_EN: when defined, AES-192/256 are supported and the store holds 60
// words; when undefined, key_len is ignored (AES-128 only) and the store holds 44 words.
module aes_key_expand
    import aes_const::*;
#(
`ifdef AES_KEY_LONG_EN
    parameter int NW = 60
`else
    parameter int NW = 44
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      SBox [0:255],
    input  logic [7:0]      RCon [0:15],
    aes_key_expand_if.slave kx
);

    state_e      state_q, state_d;
    logic [5:0]  i_q, i_d;          // index of the word being produced
    logic [2:0]  phase_q, phase_d;  // i mod Nk
    logic [3:0]  round_q, round_d;  // i / Nk
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic        done_q, done_d;
    logic        rk_valid_q, rk_valid_d;

    logic [31:0] w_q [NW];          // word store, deliberately not reset

    key_len_e    kl_eff;
    logic [3:0]  nk_acc, nr_acc;
    logic        load_en, exp_we;

    logic [31:0] w_prev, w_back, sub_in, sub_out, temp, w_new;
    logic [5:0]  rd_base;

`ifdef AES_KEY_LONG_EN
    assign kl_eff = key_len_e'(kx.key_len);
`else
    logic unused_key_len;
    assign unused_key_len = ^kx.key_len;
    assign kl_eff = KEY_128;
`endif

    assign nk_acc = nk_of(kl_eff);
    assign nr_acc = nr_of(kl_eff);

    // ---------------- word recurrence ----------------
    assign w_prev = w_q[i_q - 6'd1];
    assign w_back = w_q[i_q - {2'b00, nk_q}];
    // RotWord only feeds the S-box on the first word of each Nk group.
    assign sub_in = (phase_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sub_word u_sub_word (
        .sbox_i (SBox),
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        temp = w_prev;
        if (phase_q == 3'd0) begin
            temp = sub_out ^ {RCon[round_q], 24'h0};
        end
`ifdef AES_KEY_LONG_EN
        else if (nk_q == 4'd8 && phase_q == 3'd4) begin
            temp = sub_out;
        end
`endif
        w_new = w_back ^ temp;
    end

    // ---------------- FSM and counters ----------------
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        phase_d    = phase_q;
        round_d    = round_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        done_d     = 1'b0;
        rk_valid_d = rk_valid_q;
        load_en    = 1'b0;
        exp_we     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (kx.start) begin
                    load_en    = 1'b1;
                    nk_d       = nk_acc;
                    nr_d       = nr_acc;
                    i_d        = {2'b00, nk_acc};
                    phase_d    = 3'd0;
                    round_d    = 4'd1;
                    rk_valid_d = 1'b0;
                    state_d    = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                exp_we = 1'b1;
                i_d    = i_q + 6'd1;
                if ({1'b0, phase_q} == nk_q - 4'd1) begin
                    phase_d = 3'd0;
                    round_d = round_q + 4'd1;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
                // Last word index is 4*(Nr+1)-1.
                if (i_q == {nr_q, 2'b00} + 6'd3) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    rk_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            phase_q    <= '0;
            round_q    <= '0;
            nk_q       <= '0;
            nr_q       <= '0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            phase_q    <= phase_d;
            round_q    <= round_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // ---------------- word store ----------------
    always_ff @(posedge clock) begin
        if (load_en) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) < nk_acc) begin
                    w_q[j] <= kx.key[255 - 32*j -: 32];
                end
            end
        end else if (exp_we) begin
            w_q[i_q] <= w_new;
        end
    end

    // ---------------- status and read port ----------------
    assign kx.ready    = (state_q != ST_EXPAND);
    assign kx.busy     = (state_q == ST_EXPAND);
    assign kx.done     = done_q;
    assign kx.rk_valid = rk_valid_q;

    // nr_q never exceeds 14, so address 15 always falls in the zero branch.
    always_comb begin
        rd_base = '0;
        kx.rk   = '0;
        if (rk_valid_q && kx.rk_addr <= nr_q) begin
            rd_base = {kx.rk_addr, 2'b00};
            kx.rk   = {w_q[rd_base], w_q[rd_base + 6'd1],
                       w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
`timescale 1ns/1ps
module tb_aes_key_expand;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0] sbox_tb [0:255];
    logic [7:0] rcon_tb [0:15];

    aes_key_expand_if kx ();

    aes_key_expand dut (
        .clock (clock),
        .reset (reset),
        .SBox  (sbox_tb),
        .RCon  (rcon_tb),
        .kx    (kx)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- table construction from GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_tb[x] = s;
        end
        rcon_tb[0] = 8'h8d;
        rcon_tb[1] = 8'h01;
        for (int r = 2; r < 16; r++) rcon_tb[r] = gmul(rcon_tb[r-1], 8'h02);
    endtask

    // ---------------- reference key schedule ----------------
    logic [31:0] mw [0:59];
    int mnk, mnr;

    function automatic int eff_kl(input logic [1:0] kl);
`ifdef AES_KEY_LONG_EN
        return (kl == 2'd3) ? 0 : int'(kl);
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
    endfunction

    function automatic void model_expand(input logic [255:0] k, input logic [1:0] kl);
        logic [31:0] t;
        int e;
        e   = eff_kl(kl);
        mnk = (e == 1) ? 6 : (e == 2) ? 8 : 4;
        mnr = mnk + 6;
        for (int i = 0; i < 60; i++) mw[i] = 32'h0;
        for (int i = 0; i < mnk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = mnk; i < 4*(mnr+1); i++) begin
            t = mw[i-1];
            if (i % mnk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_tb[i / mnk], 24'h0};
            else if (mnk == 8 && i % 8 == 4)
                t = subw(t);
            mw[i] = mw[i - mnk] ^ t;
        end
    endfunction

    function automatic logic [127:0] model_rk(input int a);
        if (a > mnr) return 128'h0;
        return {mw[4*a], mw[4*a+1], mw[4*a+2], mw[4*a+3]};
    endfunction

    function automatic int model_lat();
        return 4*(mnr+1) - mnk;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_req(input logic [255:0] k, input logic [1:0] kl);
        @(negedge clock);
        kx.key = k; kx.key_len = kl; kx.start = 1'b1;
        @(posedge clock);
        #1 kx.start = 1'b0;
    endtask

    // Waits (bounded) for done; optionally pulses start with a different key at cycle `poke`.
    task automatic wait_done(input int poke, output int cyc, output logic first_ok);
        cyc = -1;
        first_ok = 1'b0;
        for (int n = 1; n <= 200 && cyc < 0; n++) begin
            @(posedge clock);
            @(negedge clock);
            kx.start = 1'b0;
            if (n == 1) first_ok = kx.busy && !kx.ready && !kx.rk_valid && !kx.done;
            if (kx.done) cyc = n;
            else if (n == poke) begin
                kx.start = 1'b1; kx.key = ~kx.key; kx.key_len = 2'd0;
            end
        end
    endtask

    task automatic read_rk(input int a, output logic [127:0] v);
        @(negedge clock);
        kx.rk_addr = 4'(a);
        #1 v = kx.rk;
    endtask

    task automatic check_pulse();
        @(negedge clock);
        chk("done_pulse_ends", {127'h0, kx.done}, 128'h0);
        chk("rk_valid_held", {127'h0, kx.rk_valid}, 128'h1);
        chk("ready_in_done", {127'h0, kx.ready}, 128'h1);
    endtask

    task automatic check_all_rk(input string tag);
        logic [127:0] v;
        for (int a = 0; a < 16; a++) begin
            read_rk(a, v);
            chk($sformatf("%s_rk%0d", tag, a), v, model_rk(a));
        end
    endtask

    task automatic run_and_check(input string tag, input logic [255:0] k, input logic [1:0] kl,
                                 input int poke);
        int cyc;
        logic first_ok;
        start_req(k, kl);
        wait_done(poke, cyc, first_ok);
        model_expand(k, kl);
        chk({tag, "_latency"}, 128'(cyc), 128'(model_lat()));
        chk({tag, "_first_cycle"}, {127'h0, first_ok}, 128'h1);
        check_pulse();
        check_all_rk(tag);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [255:0] key;
        logic [1:0]   kl;
        int           lat;
        int           w_idx;
        logic [31:0]  w_exp;
        int           last_a;
        logic [127:0] rk_exp;
        int           hi_a;
    } vec_t;

    vec_t vt [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, dseen;
        logic first_ok;
        logic [127:0] v;
        logic [255:0] rkey;
        logic [1:0] rkl;

        build_tables();
        vt.push_back('{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, 40, 4, 32'ha0fafe17,
                       10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11});
`ifdef AES_KEY_LONG_EN
        vt.push_back('{{192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'd1, 46, 6,
                       32'hfe0c91f7, 12, 128'he98ba06f448c773c8ecc720401002202, 13});
        vt.push_back('{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'd2,
                       52, 8, 32'h9ba35411, 14, 128'hfe4890d1e6188d0b046df344706c631e, 15});
`else
        vt.push_back('{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd2, 40, 4, 32'ha0fafe17,
                       10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11});
`endif

        // Reset state.
        reset = 1'b1;
        kx.key = '0; kx.key_len = 2'd0; kx.start = 1'b0; kx.rk_addr = 4'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ready", {127'h0, kx.ready}, 128'h1);
        chk("reset_busy", {127'h0, kx.busy}, 128'h0);
        chk("reset_done", {127'h0, kx.done}, 128'h0);
        chk("reset_rk_valid", {127'h0, kx.rk_valid}, 128'h0);
        chk("reset_rk", kx.rk, 128'h0);
        reset = 1'b0;

        // Known-answer vectors.
        for (int t = 0; t < vt.size(); t++) begin
            start_req(vt[t].key, vt[t].kl);
            wait_done(0, cyc, first_ok);
            chk($sformatf("kat%0d_latency", t), 128'(cyc), 128'(vt[t].lat));
            chk($sformatf("kat%0d_first_cycle", t), {127'h0, first_ok}, 128'h1);
            check_pulse();
            read_rk(vt[t].w_idx / 4, v);
            chk($sformatf("kat%0d_w%0d", t, vt[t].w_idx),
                128'(v[127 - 32*(vt[t].w_idx % 4) -: 32]), 128'(vt[t].w_exp));
            read_rk(vt[t].last_a, v);
            chk($sformatf("kat%0d_last_rk", t), v, vt[t].rk_exp);
            read_rk(vt[t].hi_a, v);
            chk($sformatf("kat%0d_rk_out_of_range", t), v, 128'h0);
            model_expand(vt[t].key, vt[t].kl);
            check_all_rk($sformatf("kat%0d", t));
        end

        // Restart from DONE with AES-256; a start pulse at cycle 5 must be ignored.
        run_and_check("poke", vt[vt.size()-1].key, 2'd2, 5);

        // Reset at cycle 20 of an AES-256 run aborts without done.
        start_req({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  2'd2);
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ready", {127'h0, kx.ready}, 128'h1);
        chk("abort_busy", {127'h0, kx.busy}, 128'h0);
        chk("abort_rk_valid", {127'h0, kx.rk_valid}, 128'h0);
        chk("abort_rk", kx.rk, 128'h0);
        @(negedge clock);
        reset = 1'b0;
        dseen = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (kx.done || kx.rk_valid || kx.busy) dseen++;
        end
        chk("abort_no_done", 128'(dseen), 128'h0);
        run_and_check("post_abort", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'd0, 0);

        // Randomized keys and key lengths (including the reserved encoding).
        for (int r = 0; r < 8; r++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rkl  = 2'($urandom_range(0, 3));
            run_and_check($sformatf("rnd%0d", r), rkey, rkl, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
